// File: rtl/seq_shift_rotate.sv
// Bit-serial rotate/shift engine (ROL, ROR, LSL, ASR) moving the operand one position per clock.
// Latency: done strobes the cycle after the amount-th step edge (amount=0: right after the start edge).
// Backpressure: start is ignored while busy; a start during the done cycle is accepted with no gap.
module seq_shift_rotate #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M_ROL = 2'b00,
        M_ROR = 2'b01,
        M_LSL = 2'b10,
        M_ASR = 2'b11
    } mode_t;

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] step_res;
    logic             step_carry;
    logic             accept;

    always_comb begin
        step_res   = result_q;
        step_carry = carry_q;
        case (mode_q)
            M_ROL: begin
                step_res   = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
                step_carry = result_q[WIDTH-1];
            end
            M_ROR: begin
                step_res   = {result_q[0], result_q[WIDTH-1:1]};
                step_carry = result_q[0];
            end
            M_LSL: begin
                step_res   = {result_q[WIDTH-2:0], 1'b0};
                step_carry = result_q[WIDTH-1];
            end
            M_ASR: begin
                step_res   = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
                step_carry = result_q[0];
            end
            default: ;
        endcase
    end

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        result_d = result_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_RUN: begin
                result_d = step_res;
                carry_d  = step_carry;
                cnt_d    = cnt_q - 1'b1;
                state_d  = (cnt_q <= 1) ? S_DONE : S_RUN;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A new request overrides the DONE->IDLE return so back-to-back ops have no gap.
        if (accept) begin
            mode_d   = mode_t'(mode);
            result_d = data_in;
            carry_d  = 1'b0;
            cnt_d    = amount;
            state_d  = (amount != '0) ? S_RUN : S_DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mode_q   <= M_ROL;
            result_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_shift_rotate.sv
// Scoreboard bench for seq_shift_rotate: a driver queues expected results from an arithmetic
// reference model; a monitor checks result, carry and busy-cycle count on every done strobe.
module tb_seq_shift_rotate;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [4:0]    amount;
    logic [W-1:0]  data_in;
    logic [W-1:0]  result;
    logic          carry;
    logic          busy;
    logic          done;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic [4:0]   amt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   busy_cnt = 0;

    seq_shift_rotate #(.WIDTH(W), .AMT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .amount(amount),
        .data_in(data_in), .result(result), .carry(carry), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] m, input int n, input logic [W-1:0] x);
        exp_t e;
        int   k;
        e.amt = n[4:0];
        e.res = x;
        e.c   = 1'b0;
        if (n != 0) begin
            case (m)
                2'b00: begin
                    k     = n % W;
                    e.res = (k == 0) ? x : ((x << k) | (x >> (W - k)));
                    e.c   = e.res[0];
                end
                2'b01: begin
                    k     = n % W;
                    e.res = (k == 0) ? x : ((x >> k) | (x << (W - k)));
                    e.c   = e.res[W-1];
                end
                2'b10: begin
                    e.res = (n >= W) ? '0 : (x << n);
                    e.c   = (n <= W) ? x[W-n] : 1'b0;
                end
                default: begin
                    e.res = (n >= W) ? {W{x[W-1]}} : W'($signed(x) >>> n);
                    e.c   = (n <= W) ? x[n-1] : x[W-1];
                end
            endcase
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: counts busy cycles and checks each completed operation against the queue head.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 16'd1, 16'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("carry", {15'd0, carry}, {15'd0, e.c});
                    check("busy_cycles", 16'(busy_cnt), {11'd0, e.amt});
                end
                busy_cnt = 0;
            end
        end
    end

    // Called at a negedge; presents one request for a cycle, queueing it if it will be accepted.
    task automatic issue(input logic [1:0] m, input int n, input logic [W-1:0] x);
        mode    = m;
        amount  = n[4:0];
        data_in = x;
        start   = 1'b1;
        if (!busy) sb.push_back(model(m, n, x));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!done) check("done_timeout", 16'd0, 16'd1);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        mode    = 2'b00;
        amount  = '0;
        data_in = '0;
        #12;
        check("rst_result", result, 16'h0000);
        check("rst_flags", {13'd0, carry, busy, done}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue(2'b00, 8, 16'h00F0);  wait_done(); @(negedge clk);
        issue(2'b01, 4, 16'h00F1);  wait_done();
        issue(2'b10, 1, 16'h8001);  wait_done(); @(negedge clk);
        issue(2'b11, 3, 16'h8000);  wait_done(); @(negedge clk);
        issue(2'b11, 20, 16'h8000); wait_done(); @(negedge clk);
        issue(2'b01, 0, 16'hA5A5);
        check("amt0_busy", {15'd0, busy}, 16'd0);
        wait_done(); @(negedge clk);
        issue(2'b10, 16, 16'h00F0); wait_done(); @(negedge clk);
        issue(2'b00, 16, 16'h1234); wait_done(); @(negedge clk);
        issue(2'b01, 16, 16'h1234); wait_done(); @(negedge clk);

        // Start held through RUN with changing inputs; only the done-cycle request counts.
        begin
            int t = 0;
            mode = 2'b00; amount = 5'd5; data_in = 16'h0F0F; start = 1'b1;
            sb.push_back(model(2'b00, 5, 16'h0F0F));
            @(negedge clk);
            while (!done && t < 100) begin
                mode = 2'($urandom); amount = 5'($urandom); data_in = 16'($urandom);
                @(negedge clk);
                t++;
            end
            if (!done) begin
                check("hold_timeout", 16'd0, 16'd1);
            end else begin
                mode = 2'b10; amount = 5'd2; data_in = 16'hC003;
                sb.push_back(model(2'b10, 2, 16'hC003));
                @(negedge clk);
            end
            start = 1'b0;
            wait_done(); @(negedge clk);
        end

        // Asynchronous reset pulse inside a RUN of 10 steps.
        issue(2'b00, 10, 16'hBEEF);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_result", result, 16'h0000);
        check("arst_flags", {13'd0, carry, busy, done}, 16'd0);
        sb.delete();
        busy_cnt = 0;
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {13'd0, carry, busy, done}, 16'd0);
        issue(2'b01, 3, 16'h0007); wait_done(); @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom), int'($urandom_range(0, 31)), 16'($urandom));
            wait_done();
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("sb_empty", 16'(sb.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_shift_rotate.md
Name: seq_shift_rotate

Overview:
Multi-cycle shift/rotate engine that generalises the team's fixed 16-bit, rotate-by-8 opcode rotator. Width is parametrised, shift amount is a run-time input, and there are four modes. Moves the operand one bit position per clock and reports completion with a start/busy/done handshake and a carry-out bit. Used as a low-area shifter beside the ALU wherever single-cycle barrel-shifter area is not justified.

Parameters:
WIDTH, 16, operand/result width in bits (>=2)
AMT_W, 5, width of the shift-amount input; max step count 2^AMT_W-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled on rising clk, accepted only when not busy
mode  input  2  00 rotate left, 01 rotate right, 10 logical shift left, 11 arithmetic shift right
amount  input  AMT_W  number of 1-bit steps to perform
data_in  input  WIDTH  operand, captured on accepted start
result  output  WIDTH  working/final value
carry  output  1  last bit moved across the operand boundary
busy  output  1  high while steps remain
done  output  1  one-cycle completion strobe

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE, result=0, carry=0, busy=0, done=0, step counter=0. The operation in flight is discarded.
- States:
  - IDLE: waiting for start.
  - RUN: busy=1.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy = (state==RUN). done = (state==DONE).
- Accept rule: start is accepted in IDLE or DONE. start in RUN is ignored, with no effect on data, mode or count.
- On an accepted start edge:
  - Latch mode into an internal register.
  - result <= data_in, carry <= 0, cnt <= amount.
  - Next state: RUN if amount!=0, else DONE.
- Each RUN edge performs one step and decrements cnt. When cnt==1 at the edge, next state is DONE; otherwise stay in RUN.
- Step definitions (W=WIDTH):
  - ROL: result <= {result[W-2:0], result[W-1]}; carry <= result[W-1]
  - ROR: result <= {result[0], result[W-1:1]}; carry <= result[0]
  - LSL: result <= {result[W-2:0], 1'b0}; carry <= result[W-1]
  - ASR: result <= {result[W-1], result[W-1:1]}; carry <= result[0]
- Latency: with the start edge as E0, done is high in the cycle after edge EN, where N=amount (N=0 gives done right after E0). busy is high for exactly N cycles.
- amount >= WIDTH is legal and is not reduced:
  - Rotates by WIDTH return the original value.
  - LSL by >=WIDTH gives 0.
  - ASR by >=WIDTH gives all sign bits.
- result and carry hold their final values from DONE until the next accepted start or reset.
- Back-to-back: start asserted while done=1 is accepted. The next operation starts at that edge with no idle gap, and done drops.
- mode and data_in are don't-care except on an accepted start edge.
- Illegal/unreachable state encodings recover to IDLE.

Test Plan:
- WIDTH=16: data_in=16'h00F0, mode=00, amount=8, start 1 cycle -> busy high 8 cycles, then done pulse; result=16'hF000, carry=0.
- data_in=16'h00F1, mode=01, amount=4 -> result=16'h100F, carry=0 (orig bit3). Then data_in=16'h8001, mode=10, amount=1 issued in the done cycle -> accepted back-to-back; result=16'h0002, carry=1.
- data_in=16'h8000, mode=11, amount=3 -> result=16'hF000, carry=0. With amount=20 -> result=16'hFFFF, carry=1.
- amount=0, data_in=16'hA5A5, any mode -> busy never rises, done the cycle after start, result=16'hA5A5, carry=0. Also mode=10, amount=16, data_in=16'h00F0 -> result=16'h0000, carry=0.
- Start held high during RUN with different data_in/mode -> ignored; original operation's result unchanged; a new operation begins only at the done cycle.
- Assert reset for part of a cycle during RUN of amount=10 -> all outputs 0 immediately (asynchronously), IDLE after release, next start behaves normally.
